// File: rtl/counter_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : counter_arbiter
// Description : Round-robin shared up/down counter serving two requesters,
//               with a one-cycle response channel.
// Revision    : 1.0  initial release
// ============================================================================
module counter_arbiter #(
  parameter int WIDTH = 16,
  parameter int STEP  = 1
) (
  input  logic             clock,
  input  logic             reset_,
  input  logic             req_0_valid,
  input  logic [1:0]       req_0_op,
  input  logic [WIDTH-1:0] req_0_data,
  output logic             req_0_ready,
  input  logic             req_1_valid,
  input  logic [1:0]       req_1_op,
  input  logic [WIDTH-1:0] req_1_data,
  output logic             req_1_ready,
  output logic             resp_valid,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_value,
  output logic [WIDTH-1:0] count
);

  localparam logic [1:0] C_OP_LOAD = 2'b00;
  localparam logic [1:0] C_OP_INC  = 2'b01;
  localparam logic [1:0] C_OP_DEC  = 2'b10;
  localparam logic [1:0] C_OP_READ = 2'b11;

  localparam logic [WIDTH-1:0] C_STEP = WIDTH'(STEP);

  logic             r_last_grant;
  logic             r_resp_valid;
  logic             r_resp_id;
  logic [WIDTH-1:0] r_resp_value;
  logic [WIDTH-1:0] r_count;

  logic             w_grant_0;
  logic             w_grant_1;
  logic             w_accept;
  logic [1:0]       w_op;
  logic [WIDTH-1:0] w_data;
  logic [WIDTH-1:0] w_next;

  // Under contention the requester that did not win last time gets the slot;
  // readies are forced low while reset is held.
  always_comb begin
    w_grant_0 = 1'b0;
    w_grant_1 = 1'b0;
    if (reset_) begin
      w_grant_0 = req_0_valid & (~req_1_valid | r_last_grant);
      w_grant_1 = req_1_valid & (~req_0_valid | ~r_last_grant);
    end
  end

  assign w_accept = w_grant_0 | w_grant_1;
  assign w_op     = w_grant_1 ? req_1_op   : req_0_op;
  assign w_data   = w_grant_1 ? req_1_data : req_0_data;

  always_comb begin
    w_next = r_count;
    case (w_op)
      C_OP_LOAD: w_next = w_data;
      C_OP_INC:  w_next = r_count + C_STEP;
      C_OP_DEC:  w_next = r_count - C_STEP;
      C_OP_READ: w_next = r_count;
      default:   w_next = r_count;
    endcase
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_last_grant <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_id    <= 1'b0;
      r_resp_value <= '0;
      r_count      <= '0;
    end else begin
      r_resp_valid <= w_accept;
      if (w_accept) begin
        r_count      <= w_next;
        r_resp_value <= w_next;
        r_resp_id    <= w_grant_1;
        r_last_grant <= w_grant_1;
      end
    end
  end

  assign req_0_ready = w_grant_0;
  assign req_1_ready = w_grant_1;
  assign resp_valid  = r_resp_valid;
  assign resp_id     = r_resp_id;
  assign resp_value  = r_resp_value;
  assign count       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_counter_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_arbiter
// Description : Directed self-checking bench for counter_arbiter.
// Revision    : 1.0  initial release
// ============================================================================
module tb_counter_arbiter;

  localparam int WIDTH = 16;

  logic             clock;
  logic             reset_;
  logic             req_0_valid, req_1_valid;
  logic [1:0]       req_0_op, req_1_op;
  logic [WIDTH-1:0] req_0_data, req_1_data;
  logic             req_0_ready, req_1_ready;
  logic             resp_valid, resp_id;
  logic [WIDTH-1:0] resp_value, count;

  logic             s4_0_valid;
  logic [1:0]       s4_0_op;
  logic [WIDTH-1:0] s4_0_data;
  logic             s4_0_ready, s4_1_ready;
  logic             s4_resp_valid, s4_resp_id;
  logic [WIDTH-1:0] s4_resp_value, s4_count;

  int checks = 0;
  int errors = 0;

  counter_arbiter #(.WIDTH(WIDTH), .STEP(1)) dut (
    .clock(clock), .reset_(reset_),
    .req_0_valid(req_0_valid), .req_0_op(req_0_op), .req_0_data(req_0_data),
    .req_0_ready(req_0_ready),
    .req_1_valid(req_1_valid), .req_1_op(req_1_op), .req_1_data(req_1_data),
    .req_1_ready(req_1_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_value(resp_value),
    .count(count)
  );

  counter_arbiter #(.WIDTH(WIDTH), .STEP(4)) dut_s4 (
    .clock(clock), .reset_(reset_),
    .req_0_valid(s4_0_valid), .req_0_op(s4_0_op), .req_0_data(s4_0_data),
    .req_0_ready(s4_0_ready),
    .req_1_valid(1'b0), .req_1_op(2'b00), .req_1_data('0),
    .req_1_ready(s4_1_ready),
    .resp_valid(s4_resp_valid), .resp_id(s4_resp_id), .resp_value(s4_resp_value),
    .count(s4_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [1:0] op0, input logic [WIDTH-1:0] d0,
                       input logic v1, input logic [1:0] op1, input logic [WIDTH-1:0] d1);
    req_0_valid = v0; req_0_op = op0; req_0_data = d0;
    req_1_valid = v1; req_1_op = op1; req_1_data = d1;
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  logic [WIDTH-1:0] exp_vals [4];
  logic             exp_ids  [4];

  initial begin
    reset_ = 1'b0;
    drive(1'b1, 2'b01, 16'h0, 1'b1, 2'b01, 16'h0);
    s4_0_valid = 1'b0; s4_0_op = 2'b00; s4_0_data = '0;
    #2;
    check("rst_count", 32'(count), 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_id", 32'(resp_id), 32'h0);
    check("rst_resp_value", 32'(resp_value), 32'h0);
    check("rst_ready0", 32'(req_0_ready), 32'h0);
    check("rst_ready1", 32'(req_1_ready), 32'h0);
    drive(1'b0, 2'b00, 16'h0, 1'b0, 2'b00, 16'h0);
    #10 reset_ = 1'b1;
    cyc();

    // Lone load from requester 0
    drive(1'b1, 2'b00, 16'h1234, 1'b0, 2'b00, 16'h0);
    #1;
    check("load_ready0", 32'(req_0_ready), 32'h1);
    check("load_ready1", 32'(req_1_ready), 32'h0);
    cyc();
    drive(1'b0, 2'b00, 16'h0, 1'b0, 2'b00, 16'h0);
    check("load_resp_valid", 32'(resp_valid), 32'h1);
    check("load_resp_id", 32'(resp_id), 32'h0);
    check("load_resp_value", 32'(resp_value), 32'h1234);
    check("load_count", 32'(count), 32'h1234);

    // Requester 1 loads 0x0010, leaving requester 0 next in line
    drive(1'b0, 2'b00, 16'h0, 1'b1, 2'b00, 16'h0010);
    cyc();
    check("seed_resp_id", 32'(resp_id), 32'h1);
    check("seed_count", 32'(count), 32'h0010);

    // Continuous contention: inc from 0, dec from 1
    exp_vals[0] = 16'h0011; exp_vals[1] = 16'h0010;
    exp_vals[2] = 16'h0011; exp_vals[3] = 16'h0010;
    exp_ids[0] = 1'b0; exp_ids[1] = 1'b1; exp_ids[2] = 1'b0; exp_ids[3] = 1'b1;
    drive(1'b1, 2'b01, 16'h0, 1'b1, 2'b10, 16'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rr_ready0_%0d", i), 32'(req_0_ready), 32'(!exp_ids[i]));
      check($sformatf("rr_ready1_%0d", i), 32'(req_1_ready), 32'(exp_ids[i]));
      cyc();
      check($sformatf("rr_valid_%0d", i), 32'(resp_valid), 32'h1);
      check($sformatf("rr_id_%0d", i), 32'(resp_id), 32'(exp_ids[i]));
      check($sformatf("rr_value_%0d", i), 32'(resp_value), 32'(exp_vals[i]));
    end

    // Wrap around both directions via requester 1
    drive(1'b0, 2'b00, 16'h0, 1'b1, 2'b00, 16'hFFFF);
    cyc();
    drive(1'b0, 2'b00, 16'h0, 1'b1, 2'b01, 16'h0);
    cyc();
    check("wrap_inc_value", 32'(resp_value), 32'h0000);
    check("wrap_inc_id", 32'(resp_id), 32'h1);
    drive(1'b0, 2'b00, 16'h0, 1'b1, 2'b10, 16'h0);
    cyc();
    check("wrap_dec_value", 32'(resp_value), 32'hFFFF);
    check("wrap_dec_count", 32'(count), 32'hFFFF);

    // Read then idle
    drive(1'b1, 2'b00, 16'h00AA, 1'b0, 2'b00, 16'h0);
    cyc();
    drive(1'b1, 2'b11, 16'h5A5A, 1'b0, 2'b00, 16'h0);
    cyc();
    check("read_valid", 32'(resp_valid), 32'h1);
    check("read_value", 32'(resp_value), 32'h00AA);
    check("read_count", 32'(count), 32'h00AA);
    drive(1'b0, 2'b00, 16'h0, 1'b0, 2'b00, 16'h0);
    cyc();
    check("idle_valid", 32'(resp_valid), 32'h0);
    check("idle_value", 32'(resp_value), 32'h00AA);
    check("idle_count", 32'(count), 32'h00AA);

    // Lone grant to 1, then contention goes to 0
    drive(1'b0, 2'b00, 16'h0, 1'b1, 2'b11, 16'h0);
    cyc();
    drive(1'b1, 2'b11, 16'h0, 1'b1, 2'b11, 16'h0);
    #1;
    check("after1_ready0", 32'(req_0_ready), 32'h1);
    check("after1_ready1", 32'(req_1_ready), 32'h0);
    cyc();
    check("after1_resp_id", 32'(resp_id), 32'h0);

    // STEP=4 instance: 0x0002 - 4 wraps to 0xFFFE
    drive(1'b0, 2'b00, 16'h0, 1'b0, 2'b00, 16'h0);
    s4_0_valid = 1'b1; s4_0_op = 2'b00; s4_0_data = 16'h0002;
    cyc();
    check("s4_load_count", 32'(s4_count), 32'h0002);
    s4_0_op = 2'b10;
    cyc();
    s4_0_valid = 1'b0;
    check("s4_dec_value", 32'(s4_resp_value), 32'hFFFE);
    check("s4_dec_count", 32'(s4_count), 32'hFFFE);

    // Asynchronous reset while a lone requester-1 load is pending
    drive(1'b0, 2'b00, 16'h0, 1'b1, 2'b00, 16'h5555);
    cyc();
    check("pre_rst_count", 32'(count), 32'h5555);
    #2;
    reset_ = 1'b0;
    #1;
    check("mid_rst_count", 32'(count), 32'h0);
    check("mid_rst_resp_valid", 32'(resp_valid), 32'h0);
    check("mid_rst_ready0", 32'(req_0_ready), 32'h0);
    check("mid_rst_ready1", 32'(req_1_ready), 32'h0);
    cyc();
    check("held_rst_count", 32'(count), 32'h0);
    #3 reset_ = 1'b1;
    drive(1'b1, 2'b11, 16'h0, 1'b1, 2'b11, 16'h0);
    #1;
    check("post_rst_ready0", 32'(req_0_ready), 32'h1);
    check("post_rst_ready1", 32'(req_1_ready), 32'h0);
    cyc();
    check("post_rst_resp_id", 32'(resp_id), 32'h0);
    check("post_rst_count", 32'(count), 32'h0);
    drive(1'b0, 2'b00, 16'h0, 1'b0, 2'b00, 16'h0);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
